// File: rtl/seq_mul_unit_if.sv
// Operand/result bundle between the execute stage and the iterative multiplier.
interface seq_mul_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [1:0]      funct;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, funct, rs1, rs2,
    input  busy, done, result
  );

  modport slave (
    input  start, flush, funct, rs1, rs2,
    output busy, done, result
  );
endinterface

// File: rtl/seq_mul_unit.sv
// Radix-2 shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Sign-magnitude: operands are made unsigned at launch, product negated in FIX.
module seq_mul_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  seq_mul_unit_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_FIX
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      funct_q, funct_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            sign_q, sign_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            rs1_neg, rs2_neg;
  logic [XLEN:0]   sum;
  logic [PW-1:0]   prod_fix;

  always_comb begin
    rs1_neg  = ((bus.funct == 2'b01) || (bus.funct == 2'b10)) && bus.rs1[XLEN-1];
    rs2_neg  = (bus.funct == 2'b01) && bus.rs2[XLEN-1];
    // Carry out of the upper-half add becomes the new MSB after the shift.
    sum      = {1'b0, prod_q[PW-1:XLEN]} + {1'b0, mcand_q};
    prod_fix = sign_q ? (~prod_q + PW'(1)) : prod_q;

    state_d  = state_q;
    funct_d  = funct_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_d  = ST_CALC;
          funct_d  = bus.funct;
          mcand_d  = rs1_neg ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
          mplier_d = rs2_neg ? (~bus.rs2 + XLEN'(1)) : bus.rs2;
          sign_d   = rs1_neg ^ rs2_neg;
          prod_d   = '0;
          cnt_d    = '0;
        end
      end
      ST_CALC: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          if (mplier_q[0]) prod_d = {sum, prod_q[XLEN-1:1]};
          else             prod_d = {1'b0, prod_q[PW-1:1]};
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          result_d = (funct_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[PW-1:XLEN];
          done_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      funct_q  <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct_q  <= funct_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
endmodule

// File: doc/seq_mul_unit.md
Name: seq_mul_unit

Overview:
- Iterative radix-2 shift-and-add multiplier for the RV32 execute stage.
- Complements the ALU subtract path and covers the RV32M MUL/MULH/MULHSU/MULHU group.
- Takes operands with a Start pulse, iterates one partial product per clock, and returns one XLEN-bit result with a single-cycle Done strobe.
- Sits beside the ALU. The pipeline stalls on Busy.

Parameters:
- XLEN, 32, operand and result width. Must be ≥ 4.

Ports:
- CLK  input  1  rising-edge clock
- RST  input  1  asynchronous, active-high reset
- Start  input  1  launch request; sampled only when Busy=0
- Flush  input  1  synchronous abort of an in-flight operation (pipeline kill)
- Funct  input  2  00 MUL (low half), 01 MULH (signed×signed, high), 10 MULHSU (signed Rs1 × unsigned Rs2, high), 11 MULHU (unsigned×unsigned, high)
- Rs1  input  XLEN  multiplicand
- Rs2  input  XLEN  multiplier
- Busy  output  1  operation in flight; Start ignored
- Done  output  1  one-cycle strobe; Result valid from this cycle
- Result  output  XLEN  selected product half; held until the next Done

Behaviour:
- Reset: asynchronous, active-high. Forces state IDLE, Busy=0, Done=0, Result=0, internal counter/accumulators cleared. Applies even mid-operation; no Done follows.
- States:
  - IDLE: Busy=0.
  - CALC: Busy=1.
  - FIX: Busy=1.
- IDLE → CALC on a rising edge with Start=1 and Flush=0. At that edge:
  - Latch Funct.
  - Latch magnitudes: |Rs1| if Funct∈{01,10} and Rs1[XLEN-1]=1, else Rs1; |Rs2| if Funct=01 and Rs2[XLEN-1]=1, else Rs2. Magnitudes are unsigned XLEN bits, so −2^(XLEN−1) maps to 2^(XLEN−1).
  - Latch result sign = XOR of the applicable operand signs.
  - Clear the 2·XLEN-bit product and the counter.
- CALC, one iteration per edge, exactly XLEN edges:
  - If multiplier LSB=1, add the multiplicand (zero-extended) into the upper half of the product accumulator with carry-out kept.
  - Shift accumulator and multiplier right by 1.
  - Counter increments; after the XLEN-th iteration, CALC → FIX.
- FIX, one edge:
  - Two's-complement negate the full 2·XLEN product if sign=1.
  - Register Result = low half for Funct=00, high half otherwise.
  - Set Done=1, go to IDLE.
- Latency is fixed and data-independent: Start sampled at edge 0, Done=1 in the cycle after edge XLEN+1 (33 cycles for XLEN=32). No early-out for zero operands.
- Done is high for exactly one cycle.
- Back-to-back: Start=1 in the Done cycle is accepted (state is IDLE), so the next result arrives XLEN+1 cycles later.
- Start while Busy=1 is ignored. Operands may change freely after the Start edge.
- Flush=1 on any edge in CALC/FIX returns to IDLE with Busy=0 and no Done. Result keeps its previous value.
- Flush=1 in IDLE is a no-op, and it wins over a simultaneous Start.
- Funct/Rs1/Rs2 are don't-care outside the Start edge.
- All arithmetic is modulo 2^(2·XLEN). No overflow flag.

Test Plan:
- Funct=00, Rs1=7, Rs2=0xFFFFFFFD (−3), Start at edge 0 → Busy 1 for edges 0..32, Done=1 exactly one cycle after edge 33, Result=0xFFFFFFEB.
- Rs1=Rs2=0x80000000: Funct=01 → Result=0x40000000; Funct=00 → Result=0x00000000.
- Funct=10, Rs1=0xFFFFFFFF, Rs2=0xFFFFFFFF → Result=0xFFFFFFFF. Funct=11, same operands → Result=0xFFFFFFFE.
- Rs2=0, any Funct → Done still after 33 cycles, Result=0.
- Start 5×6 (Funct=00); assert Start again at edge 10 with other operands → ignored, Result=30. Start 3×4 in the Done cycle → second Done 33 cycles later, Result=12.
- Flush at edge 12 of an operation → Busy=0 next cycle, no Done, Result unchanged. Separately, RST pulsed mid-CALC asynchronously → Busy=0, Result=0 immediately, no Done. Then a new Start 2×2 → Result=4.
